term_writer: RTL and testbench



---
 rtl/term_pkg.sv | 28 ++
 rtl/term_clear_seq.sv | 59 +++++
 rtl/term_writer.sv | 212 +++++++++++++++++++++
 tb/tb_term_writer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// term_pkg: shared definitions for the character terminal engine.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - ASCII control-code constants and the printable range
//   - is_printable() helper
package term_pkg;

  // FSM states
  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StClearLine = 2'd1;
  localparam logic [1:0] StClearAll  = 2'd2;

  // ASCII codes handled by the decoder
  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_TAB   = 8'h09;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  // Printable range (inclusive)
  localparam logic [7:0] CHR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHR_PRINT_LO) && (c <= CHR_PRINT_HI);
  endfunction

endpackage

// File: rtl/term_clear_seq.sv
// term_clear_seq: column/row counter producing the clear-address sequence.
//   clk, rst_n  : clock, asynchronous active-low reset
//   step        : advance to the next cell
//   line_mode   : 1 = single-row clear (row output is line_row), 0 = full screen
//   line_row    : physical row cleared in line mode
//   col, row    : current clear address
//   done        : current cell is the last one of the sequence
// The counter wraps back to 0 on the last step, so every clear starts at {0,0}.
module term_clear_seq #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             line_mode,
  input  logic [ROW_W-1:0] line_row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             done
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (step) begin
      if (col_q == LastCol) begin
        col_d = '0;
        // Line mode never advances the row counter; it stays at 0.
        row_d = (line_mode || (row_q == LastRow)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = line_mode ? line_row : row_q;
  assign done = (col_q == LastCol) && (line_mode || (row_q == LastRow));

endmodule

// File: rtl/term_writer.sv
// term_writer: character-stream terminal engine driving VRAM port A.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : byte stream handshake (ready only in IDLE)
//   vram_addr/vram_data/vram_we : registered VRAM write port, addr = {phys_row, col}
//   cursor_col/cursor_row : logical cursor (row 0 = top of screen)
//   scroll_base  : physical row holding logical row 0
//   busy         : high while a line or full-screen clear is running
// All outputs are registered; a byte accepted in cycle N is written in N+1.
module term_writer
  import term_pkg::*;
#(
  parameter int unsigned COLS          = 80,
  parameter int unsigned ROWS          = 30,
  parameter int unsigned COL_W         = 7,
  parameter int unsigned ROW_W         = 5,
  parameter int unsigned TAB_W         = 8,
  parameter bit          LF_IMPLIES_CR = 1'b1,
  parameter bit          AUTOWRAP      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [COL_W+ROW_W-1:0] vram_addr,
  output logic [7:0]             vram_data,
  output logic                   vram_we,
  output logic [COL_W-1:0]       cursor_col,
  output logic [ROW_W-1:0]       cursor_row,
  output logic [ROW_W-1:0]       scroll_base,
  output logic                   busy
);

  localparam logic [COL_W-1:0] LastCol    = COL_W'(COLS - 1);
  localparam logic [COL_W:0]   LastColExt = (COL_W + 1)'(COLS - 1);
  localparam logic [ROW_W-1:0] LastRow    = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]   RowsExt    = (ROW_W + 1)'(ROWS);
  localparam int unsigned      TabShift   = $clog2(TAB_W);

  logic [1:0]             state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [ROW_W-1:0]       base_q, base_d;
  logic [COL_W+ROW_W-1:0] addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   we_q, we_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;

  logic [ROW_W:0]   row_sum;
  logic [ROW_W-1:0] phys_row;
  logic [COL_W:0]   tab_next;
  logic [COL_W-1:0] col_dec;
  logic             newline;

  logic             clr_step;
  logic             clr_line_mode;
  logic [COL_W-1:0] clr_col;
  logic [ROW_W-1:0] clr_row;
  logic             clr_done;

  // Physical row of the cursor; compare-and-subtract instead of modulo.
  always_comb begin
    row_sum  = {1'b0, row_q} + {1'b0, base_q};
    phys_row = (row_sum >= RowsExt) ? ROW_W'(row_sum - RowsExt) : row_sum[ROW_W-1:0];
  end

  always_comb begin
    tab_next = (({1'b0, col_q} >> TabShift) + 1'b1) << TabShift;
    col_dec  = col_q - 1'b1;
  end

  // During CLEAR_LINE the cursor sits on the bottom row, so phys_row is the
  // physical row that just became the bottom line.
  assign clr_line_mode = (state_q == StClearLine);

  term_clear_seq #(
    .COLS (COLS),
    .ROWS (ROWS),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (clr_step),
    .line_mode(clr_line_mode),
    .line_row (phys_row),
    .col      (clr_col),
    .row      (clr_row),
    .done     (clr_done)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    base_d   = base_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    newline  = 1'b0;
    clr_step = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          if (is_printable(in_data)) begin
            we_d   = 1'b1;
            data_d = in_data;
            addr_d = {phys_row, col_q};
            if (col_q == LastCol) begin
              if (AUTOWRAP) begin
                col_d   = '0;
                newline = 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (in_data)
              CHR_CR: col_d = '0;
              CHR_LF: begin
                newline = 1'b1;
                if (LF_IMPLIES_CR) col_d = '0;
              end
              CHR_BS: begin
                if (col_q != '0) begin
                  col_d  = col_dec;
                  we_d   = 1'b1;
                  data_d = CHR_SPACE;
                  addr_d = {phys_row, col_dec};
                end
              end
              CHR_TAB: col_d = (tab_next > LastColExt) ? LastCol : tab_next[COL_W-1:0];
              CHR_FF:  state_d = StClearAll;
              default: ;
            endcase
          end

          if (newline) begin
            if (row_q != LastRow) begin
              row_d = row_q + 1'b1;
            end else begin
              base_d  = (base_q == LastRow) ? '0 : base_q + 1'b1;
              state_d = StClearLine;
            end
          end
        end
      end

      StClearLine: begin
        clr_step = 1'b1;
        we_d     = 1'b1;
        data_d   = CHR_SPACE;
        addr_d   = {clr_row, clr_col};
        if (clr_done) state_d = StIdle;
      end

      StClearAll: begin
        clr_step = 1'b1;
        we_d     = 1'b1;
        data_d   = CHR_SPACE;
        addr_d   = {clr_row, clr_col};
        if (clr_done) begin
          state_d = StIdle;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
        end
      end

      default: state_d = StClearAll;
    endcase

    in_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClearAll;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign vram_addr   = addr_q;
  assign vram_data   = data_q;
  assign vram_we     = we_q;
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;
  assign scroll_base = base_q;

endmodule

// File: tb/tb_term_writer.sv
// tb_term_writer: randomized + directed bench for term_writer with a
// screen-level reference model and an expected-write scoreboard.
module tb_term_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;
  localparam int TAB_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             in_data = 8'h00;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [COL_W+ROW_W-1:0] vram_addr;
  logic [7:0]             vram_data;
  logic                   vram_we;
  logic [COL_W-1:0]       cursor_col;
  logic [ROW_W-1:0]       cursor_row;
  logic [ROW_W-1:0]       scroll_base;
  logic                   busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  term_writer #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .COL_W        (COL_W),
    .ROW_W        (ROW_W),
    .TAB_W        (TAB_W),
    .LF_IMPLIES_CR(1'b1),
    .AUTOWRAP     (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_we    (vram_we),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .scroll_base(scroll_base),
    .busy       (busy)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails = 0;
  int  m_col = 0;
  int  m_row = 0;
  int  m_base = 0;
  int  exp_ready = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int paddr(input int row, input int col);
    return (((row + m_base) % ROWS) << COL_W) | col;
  endfunction

  task automatic push_wr(input int addr, input int data, input int c);
    wr_t w;
    w.addr = addr;
    w.data = data;
    w.cyc  = c;
    exp_q.push_back(w);
  endtask

  // a = cycle in which the triggering byte's own write would appear.
  task automatic model_clear_all(input int a);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_wr((r << COL_W) | c, 32'h20, a + 1 + r * COLS + c);
    m_col = 0;
    m_row = 0;
    m_base = 0;
    exp_ready = a + ROWS * COLS;
  endtask

  task automatic model_newline(input int a);
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      m_base = (m_base + 1) % ROWS;
      for (int c = 0; c < COLS; c++) push_wr(paddr(m_row, c), 32'h20, a + 1 + c);
      exp_ready = a + COLS;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int a;
    int nt;
    a = cyc;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(paddr(m_row, m_col), int'(b), a);
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_newline(a);
      end else begin
        m_col++;
      end
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: begin
          m_col = 0;
          model_newline(a);
        end
        8'h08: begin
          if (m_col > 0) begin
            m_col--;
            push_wr(paddr(m_row, m_col), 32'h20, a);
          end
        end
        8'h09: begin
          nt = (m_col / TAB_W + 1) * TAB_W;
          m_col = (nt > COLS - 1) ? COLS - 1 : nt;
        end
        8'h0C: model_clear_all(a);
        default: ;
      endcase
    end
  endtask

  // ---------------- write scoreboard ----------------
  always @(negedge clk) begin
    wr_t w;
    if (rst_n && vram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(vram_addr), w.addr);
        check("wr_data", 32'(vram_data), w.data);
        check("wr_cycle", cyc, w.cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready) begin
      if (waited > 3000) begin
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited > 0) check("held_accept_cyc", cyc, exp_ready);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (!in_ready && waited <= 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("idle_timeout", 32'd0, 32'd1);
    else if (waited > 0) check("ready_cyc", cyc, exp_ready);
    @(negedge clk);
    #1;
  endtask

  task automatic sync_check(input string tag);
    wait_idle();
    check({tag, "_col"}, 32'(cursor_col), m_col);
    check({tag, "_row"}, 32'(cursor_row), m_row);
    check({tag, "_base"}, 32'(scroll_base), m_base);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int r;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_addr", 32'(vram_addr), 32'd0);
    check("rst_data", 32'(vram_data), 32'd0);
    check("rst_cursor", {cursor_row, cursor_col}, 32'd0);
    check("rst_base", 32'(scroll_base), 32'd0);

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_clear_all(cyc);
    sync_check("reset_clear");
    check("reset_ready", 32'(in_ready), 32'd1);

    // "AB" back to back
    send_str("AB");
    sync_check("ab");
    check("ab_col_const", 32'(cursor_col), 32'd2);

    // 80 x then y: autowrap
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send("x");
    send("y");
    sync_check("wrap");
    check("wrap_pos_const", {cursor_row, cursor_col}, {5'd1, 7'd1});

    // Down to the bottom row, then scroll
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
    sync_check("to_bottom");
    check("bottom_row_const", 32'(cursor_row), 32'd29);
    send(8'h0A);
    sync_check("scroll1");
    check("scroll1_base_const", 32'(scroll_base), 32'd1);
    check("scroll1_row_const", 32'(cursor_row), 32'd29);
    send("Z");
    sync_check("after_scroll");

    // Backspace and tabs
    send(8'h0D);
    send_str("abcde");
    send(8'h08);
    sync_check("bs");
    check("bs_col_const", 32'(cursor_col), 32'd4);
    send(8'h09);
    sync_check("tab4");
    check("tab4_col_const", 32'(cursor_col), 32'd8);
    send(8'h0D);
    for (int i = 0; i < 9; i++) send(8'h09);
    send_str("ghijkl");
    send(8'h09);
    sync_check("tab78");
    check("tab78_col_const", 32'(cursor_col), 32'd79);
    send(8'h09);
    send(8'h7F);
    send(8'h01);
    sync_check("tab79_ignored");

    // Scroll up to base 7, then form feed with a byte held during the clear
    for (int i = 0; i < 6; i++) send(8'h0A);
    sync_check("scroll7");
    check("scroll7_base_const", 32'(scroll_base), 32'd7);
    send(8'h0C);
    send("Q");
    sync_check("ff");
    check("ff_pos_const", {scroll_base, cursor_row, cursor_col}, {5'd0, 5'd0, 7'd1});

    // Reset in the middle of a full clear
    send(8'h0C);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_we", 32'(vram_we), 32'd0);
    check("midrst_cursor", {scroll_base, cursor_row, cursor_col}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_clear_all(cyc);
    sync_check("midrst_clear");

    // Randomized stream
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) b = 8'($urandom_range(32, 126));
      else if (r < 72) b = 8'h0A;
      else if (r < 78) b = 8'h0D;
      else if (r < 85) b = 8'h08;
      else if (r < 91) b = 8'h09;
      else if (r < 92) b = 8'h0C;
      else begin
        b = 8'($urandom_range(0, 255));
        if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0D || b == 8'h08 ||
            b == 8'h09 || b == 8'h0C)
          b = 8'h7F;
      end
      send(b);
      if (i % 50 == 49) sync_check("rand");
    end
    sync_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
